// File: rtl/video_output_pipe.sv
// video_output_pipe: 4-stage packed-YUV to RGB565 / RGB888 / YUV422 video output pipeline.
// Optional macro VIDEO_OUTPUT_DITHER_EN adds 2x2 ordered dither ahead of RGB565 truncation.
module video_output_pipe #(
    parameter int WORD_PIX = 8,
    parameter int X_W      = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  video_de_i,
    input  logic                  video_hs_n_i,
    input  logic                  video_vs_n_i,
    input  logic [X_W-1:0]        video_next_x_i,
    input  logic [8*WORD_PIX-1:0] y_data,
    input  logic [8*WORD_PIX-1:0] u_data,
    input  logic [8*WORD_PIX-1:0] v_data,
    input  logic                  mode_709,
    input  logic [1:0]            out_fmt,
    output logic                  video_de,
    output logic                  video_hs_n,
    output logic                  video_vs_n,
    output logic [23:0]           video_data
);
    localparam int LANE_W = $clog2(WORD_PIX);
    localparam logic [10:0] C_Y = 11'd596;

    logic [7:0] y_bytes [WORD_PIX];
    logic [7:0] u_bytes [WORD_PIX];
    logic [7:0] v_bytes [WORD_PIX];

    genvar gi;
    generate
        for (gi = 0; gi < WORD_PIX; gi++) begin : g_lane
            assign y_bytes[gi] = y_data[8*gi +: 8];
            assign u_bytes[gi] = u_data[8*gi +: 8];
            assign v_bytes[gi] = v_data[8*gi +: 8];
        end
    endgenerate

    // Chroma is shared by pixel pairs, so its lane index drops x[0].
    logic [LANE_W-1:0] y_lane, uv_lane;
    logic              x_unused;
    assign y_lane   = video_next_x_i[LANE_W-1:0];
    assign uv_lane  = video_next_x_i[LANE_W:1];
    assign x_unused = ^video_next_x_i[X_W-1:LANE_W+1];

    logic       vs_prev_q, mode_act_q, vs_fall, mode_d;
    logic [1:0] fmt_act_q, fmt_d;
    assign vs_fall = vs_prev_q & ~video_vs_n_i;
    assign mode_d  = vs_fall ? mode_709 : mode_act_q;
    assign fmt_d   = vs_fall ? out_fmt  : fmt_act_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev_q  <= 1'b1;
            mode_act_q <= 1'b0;
            fmt_act_q  <= 2'd0;
        end else begin
            vs_prev_q  <= video_vs_n_i;
            mode_act_q <= mode_d;
            fmt_act_q  <= fmt_d;
        end
    end

`ifdef VIDEO_OUTPUT_DITHER_EN
    logic       de_prev_q, pix_par_q, line_par_q, pix_cur, line_d;
    logic [1:0] s1_par_q, s2_par_q, s3_par_q;
    assign pix_cur = (video_de_i & ~de_prev_q) ? 1'b0 : pix_par_q;
    always_comb begin
        line_d = vs_fall ? 1'b0 : line_par_q;
        if (de_prev_q & ~video_de_i)
            line_d = ~line_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            de_prev_q  <= 1'b0;
            pix_par_q  <= 1'b0;
            line_par_q <= 1'b0;
            s1_par_q   <= 2'd0;
            s2_par_q   <= 2'd0;
            s3_par_q   <= 2'd0;
        end else begin
            de_prev_q  <= video_de_i;
            pix_par_q  <= video_de_i ? ~pix_cur : pix_par_q;
            line_par_q <= line_d;
            s1_par_q   <= {line_par_q, pix_cur};
            s2_par_q   <= s1_par_q;
            s3_par_q   <= s2_par_q;
        end
    end
`endif

    // S1: lane select and sync/mode capture
    logic       s1_de_q, s1_hs_n_q, s1_vs_n_q, s1_x0_q, s1_mode_q;
    logic [1:0] s1_fmt_q;
    logic [7:0] s1_y_q, s1_u_q, s1_v_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_de_q <= 1'b0; s1_hs_n_q <= 1'b1; s1_vs_n_q <= 1'b1;
            s1_x0_q <= 1'b0; s1_mode_q <= 1'b0; s1_fmt_q <= 2'd0;
            s1_y_q  <= 8'd0; s1_u_q    <= 8'd0; s1_v_q    <= 8'd0;
        end else begin
            s1_de_q <= video_de_i; s1_hs_n_q <= video_hs_n_i; s1_vs_n_q <= video_vs_n_i;
            s1_x0_q <= video_next_x_i[0]; s1_mode_q <= mode_d; s1_fmt_q <= fmt_d;
            s1_y_q  <= y_bytes[y_lane];
            s1_u_q  <= u_bytes[uv_lane];
            s1_v_q  <= v_bytes[uv_lane];
        end
    end

    // S2: coefficient multiply
    logic [10:0] c_rv, c_gu, c_gv, c_bu;
    always_comb begin
        c_rv = s1_mode_q ? 11'd918  : 11'd817;
        c_gu = s1_mode_q ? 11'd109  : 11'd200;
        c_gv = s1_mode_q ? 11'd273  : 11'd416;
        c_bu = s1_mode_q ? 11'd1081 : 11'd1033;
    end

    logic        s2_de_q, s2_hs_n_q, s2_vs_n_q, s2_mode_q;
    logic [1:0]  s2_fmt_q;
    logic [7:0]  s2_y_q, s2_c_q;
    logic [19:0] s2_py_q, s2_prv_q, s2_pgu_q, s2_pgv_q, s2_pbu_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_de_q <= 1'b0; s2_hs_n_q <= 1'b1; s2_vs_n_q <= 1'b1;
            s2_mode_q <= 1'b0; s2_fmt_q <= 2'd0; s2_y_q <= 8'd0; s2_c_q <= 8'd0;
            s2_py_q <= 20'd0; s2_prv_q <= 20'd0; s2_pgu_q <= 20'd0;
            s2_pgv_q <= 20'd0; s2_pbu_q <= 20'd0;
        end else begin
            s2_de_q <= s1_de_q; s2_hs_n_q <= s1_hs_n_q; s2_vs_n_q <= s1_vs_n_q;
            s2_mode_q <= s1_mode_q; s2_fmt_q <= s1_fmt_q; s2_y_q <= s1_y_q;
            s2_c_q   <= s1_x0_q ? s1_v_q : s1_u_q;
            s2_py_q  <= {9'd0, C_Y}  * {12'd0, s1_y_q};
            s2_prv_q <= {9'd0, c_rv} * {12'd0, s1_v_q};
            s2_pgu_q <= {9'd0, c_gu} * {12'd0, s1_u_q};
            s2_pgv_q <= {9'd0, c_gv} * {12'd0, s1_v_q};
            s2_pbu_q <= {9'd0, c_bu} * {12'd0, s1_u_q};
        end
    end

    // S3: offset, round to nearest and scale back from 512
    logic signed [31:0] off_r, off_g, off_b, r_sum, g_sum, b_sum;
    always_comb begin
        off_r = s2_mode_q ? -32'sd127040 : -32'sd114112;
        off_g = s2_mode_q ?  32'sd39360  :  32'sd69312;
        off_b = s2_mode_q ? -32'sd147904 : -32'sd141760;
        r_sum = $signed({12'd0, s2_py_q}) + $signed({12'd0, s2_prv_q}) + off_r + 32'sd256;
        g_sum = $signed({12'd0, s2_py_q}) - $signed({12'd0, s2_pgu_q})
              - $signed({12'd0, s2_pgv_q}) + off_g + 32'sd256;
        b_sum = $signed({12'd0, s2_py_q}) + $signed({12'd0, s2_pbu_q}) + off_b + 32'sd256;
    end

    logic               s3_de_q, s3_hs_n_q, s3_vs_n_q;
    logic [1:0]         s3_fmt_q;
    logic [7:0]         s3_y_q, s3_c_q;
    logic signed [11:0] s3_r_q, s3_g_q, s3_b_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_de_q <= 1'b0; s3_hs_n_q <= 1'b1; s3_vs_n_q <= 1'b1;
            s3_fmt_q <= 2'd0; s3_y_q <= 8'd0; s3_c_q <= 8'd0;
            s3_r_q <= 12'sd0; s3_g_q <= 12'sd0; s3_b_q <= 12'sd0;
        end else begin
            s3_de_q <= s2_de_q; s3_hs_n_q <= s2_hs_n_q; s3_vs_n_q <= s2_vs_n_q;
            s3_fmt_q <= s2_fmt_q; s3_y_q <= s2_y_q; s3_c_q <= s2_c_q;
            s3_r_q <= 12'(r_sum >>> 9);
            s3_g_q <= 12'(g_sum >>> 9);
            s3_b_q <= 12'(b_sum >>> 9);
        end
    end

    // S4: clamp, optional dither, pack
    function automatic logic [7:0] clamp8(input logic signed [11:0] v);
        if (v < 12'sd0)
            return 8'd0;
        else if (v > 12'sd255)
            return 8'hFF;
        else
            return v[7:0];
    endfunction

    logic [7:0] r8, g8, b8;
    logic [4:0] r5, b5;
    logic [5:0] g6;
    assign r8 = clamp8(s3_r_q);
    assign g8 = clamp8(s3_g_q);
    assign b8 = clamp8(s3_b_q);

`ifdef VIDEO_OUTPUT_DITHER_EN
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    logic [1:0] dith_rb, dith_g;
    logic [7:0] r_dith, g_dith, b_dith;
    always_comb begin
        case (s3_par_q)
            2'b00:   dith_rb = 2'd0;
            2'b01:   dith_rb = 2'd2;
            2'b10:   dith_rb = 2'd3;
            default: dith_rb = 2'd1;
        endcase
        dith_g = dith_rb >> 1;
        r_dith = sat_add(r8, dith_rb);
        g_dith = sat_add(g8, dith_g);
        b_dith = sat_add(b8, dith_rb);
    end
    assign r5 = r_dith[7:3];
    assign g6 = g_dith[7:2];
    assign b5 = b_dith[7:3];
`else
    assign r5 = r8[7:3];
    assign g6 = g8[7:2];
    assign b5 = b8[7:3];
`endif

    logic [23:0] pack_d;
    always_comb begin
        case (s3_fmt_q)
            2'd1:    pack_d = {r8, g8, b8};
            2'd2:    pack_d = {8'h00, s3_y_q, s3_c_q};
            default: pack_d = {8'h00, r5, g6, b5};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            video_de   <= 1'b0;
            video_hs_n <= 1'b1;
            video_vs_n <= 1'b1;
            video_data <= 24'd0;
        end else begin
            video_de   <= s3_de_q;
            video_hs_n <= s3_hs_n_q;
            video_vs_n <= s3_vs_n_q;
            video_data <= s3_de_q ? pack_d : 24'd0;
        end
    end
endmodule

// File: doc/video_output_pipe.md
VIDEO_OUTPUT_PIPE -- requirements
Module: video_output_pipe

Interface
REQ-001 SHALL have parameter WORD_PIX, default 8, meaning pixels per packed luma word (power of 2, 2..16).
REQ-002 SHALL have parameter X_W, default 11, meaning video_next_x_i width.
REQ-003 SHALL have ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports:
- video_de_i, video_hs_n_i, video_vs_n_i  in  1 each  timing inputs; syncs active-low.
- video_next_x_i  in  X_W  pixel x index.
REQ-005 SHALL have ports y_data, u_data, v_data  in  8*WORD_PIX each  packed bytes, pixel k in bits [8k+7:8k].
REQ-006 SHALL have port mode_709  in  1: 0 selects BT.601 coefficients, 1 selects BT.709.
REQ-007 SHALL have port out_fmt  in  2: 0 RGB565, 1 RGB888, 2 YUV422, 3 reserved (treated as 0).
REQ-008 SHALL have outputs video_de, video_hs_n, video_vs_n  out  1 each, delayed timing.
REQ-009 SHALL have output video_data  out  24  pixel word.

Function
REQ-010 SHALL use a 4-stage pipeline: S1 lane select, S2 multiply, S3 sum/round/shift, S4 clamp/pack; inputs at edge N appear on outputs after edge N+4.
REQ-011 SHALL delay de/hs_n/vs_n through 4 registers so that they stay aligned with video_data.
REQ-012 SHALL select lanes in S1 as follows: Y lane = x[log2(WORD_PIX)-1:0]; U/V lane = x[log2(WORD_PIX):1].
REQ-013 SHALL compute full-precision signed sums at scale 512: R = cY*Y + cRv*V + oR; G = cY*Y - cGu*U - cGv*V + oG; B = cY*Y + cBu*U + oB.
REQ-014 SHALL use BT.601 constants: cY=596, cRv=817, cGu=200, cGv=416, cBu=1033, oR=-114112, oG=69312, oB=-141760.
REQ-015 SHALL use BT.709 constants: cY=596, cRv=918, cGu=109, cGv=273, cBu=1081, oR=-127040, oG=39360, oB=-147904.
REQ-016 SHALL add 256 to each sum in S3, then arithmetic-shift right by 9.
REQ-017 SHALL clamp in S4: a negative result gives 0; a result >255 gives 255.
REQ-018 SHALL pack as follows:
- RGB565: {8'h00, R[7:3], G[7:2], B[7:3]}.
- RGB888: {R, G, B}.
- YUV422: {8'h00, Y, C}, with C = U when the delayed x[0]=0 and C = V when x[0]=1.
REQ-019 SHALL latch mode_709 and out_fmt into active registers on the cycle video_vs_n_i goes 1->0, and SHALL hold them for the whole frame; changes at other times have no effect.
REQ-020 SHALL drive video_data to 0 whenever the aligned video_de is 0.
REQ-021 SHALL keep a pixel-parity counter that clears on the video_de_i rising edge and toggles each cycle video_de_i=1.
REQ-022 SHALL keep a line-parity bit that toggles on each video_de_i falling edge and clears on the video_vs_n_i falling edge.
REQ-023 SHALL carry both parity bits down the pipeline aligned with the pixel.
REQ-024 SHALL give priority to the frame latch when vs_n falls in the same cycle as a de edge; the parity update of that cycle still applies.

Reset
REQ-025 SHALL, while rst=1 at a clk edge, clear video_de, video_data, all pipeline data and parities to 0, and set video_hs_n and video_vs_n (including delay stages) to 1.
REQ-026 SHALL reset the active mode registers to BT.601 and RGB565.
REQ-027 SHALL, when reset is asserted mid-frame, discard in-flight pixels; the first valid output is the input presented 4 cycles after rst drops.

Configuration
REQ-028 SHALL, when macro VIDEO_OUTPUT_DITHER_EN is defined and the active format is RGB565, add a 2x2 ordered-dither offset before truncation.
- Offset is taken from {line parity, pixel parity}: 00->0, 01->2, 10->3, 11->1 for R/B; half of that value (truncated) for G.
- The sum saturates at 255.
REQ-029 SHALL, when VIDEO_OUTPUT_DITHER_EN is undefined, use plain truncation; the parity logic may be removed, and all other behaviour is identical.

Verification
REQ-030 SHALL cover: BT.601, RGB888, Y=235, U=V=128, de=1 -> video_data=24'hFFFFFF exactly 4 cycles later; Y=16 gives 24'h000000.
REQ-031 SHALL cover: BT.601, Y=81, U=90, V=240 -> RGB888 24'hFE0000; RGB565 24'h00F800 (dither off).
REQ-032 SHALL cover: Y=255, U=128, V=255 -> R clamps to 8'hFF; Y=0, U=V=128 -> all channels clamp to 0.
REQ-033 SHALL cover: WORD_PIX=8, next_x=5, y_data byte5=8'hEB, other bytes 0, U/V byte2=8'h80, others 0 -> 24'hFFFFFF; next_x=4 gives 0.
REQ-034 SHALL cover: toggle mode_709 and out_fmt mid-frame -> output unchanged until after the next vs_n falling edge, then the new mode applies.
REQ-035 SHALL cover: reset pulsed mid-line -> outputs de=0, hs_n=vs_n=1, data=0 during reset and for 4 cycles after; sync alignment is restored afterwards.
